regfile: RTL and testbench

Parametrised general-purpose register file for the CPU datapath, the successor to the single 32-bit write-enabled register. It holds DEPTH words of WIDTH bits and provides one write port with byte enables and two combinational read ports. Register 0 is optionally hardwired to zero, and reset is synchronous. It sits between instruction decode (read addresses) and writeback (write port).

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_reg_be.sv | 26 ++
 rtl/regfile.sv | 84 ++++++++
 tb/tb_regfile.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the general-purpose register file.
package regfile_pkg;

  localparam int REGFILE_WIDTH_DEF = 32;
  localparam int REGFILE_DEPTH_DEF = 32;

  function automatic int be_width(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/regfile_reg_be.sv
// One register word built from independently enabled bytes, cleared by synchronous reset.
module reg_be
  import regfile_pkg::*;
#(
  parameter int WIDTH = REGFILE_WIDTH_DEF,
  localparam int BW = be_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [BW-1:0]    be,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      for (int i = 0; i < BW; i++) begin
        if (be[i]) q[8*i +: 8] <= d[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/regfile.sv
// Register file: one byte-enabled write port, two combinational read ports.
// Define REGFILE_BYPASS_EN to forward a same-cycle write onto matching read ports.
module regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH_DEF,
  parameter int DEPTH    = REGFILE_DEPTH_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int BW      = be_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [BW-1:0]    wbe,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] words [DEPTH];
  logic [WIDTH-1:0] storedA;
  logic [WIDTH-1:0] storedB;

  // Addresses at or above DEPTH never match a word, so such writes fall away naturally.
  for (genvar g = 0; g < DEPTH; g++) begin : gen_word
    if (ZERO_REG != 0 && g == 0) begin : gen_zero
      assign words[g] = '0;
    end else begin : gen_reg
      reg_be #(.WIDTH(WIDTH)) u_reg (
        .clk(clk),
        .rst(rst),
        .en (we && (waddr == AW'(g))),
        .be (wbe),
        .d  (wdata),
        .q  (words[g])
      );
    end
  end

  always_comb begin
    storedA = '0;
    storedB = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == AW'(i)) storedA = words[i];
      if (raddr_b == AW'(i)) storedB = words[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic waddrInRange;
  logic wrLive;

  function automatic logic [WIDTH-1:0] mergeBytes(input logic [WIDTH-1:0] old,
                                                  input logic [WIDTH-1:0] fresh,
                                                  input logic [BW-1:0]    be);
    logic [WIDTH-1:0] res;
    res = old;
    for (int i = 0; i < BW; i++) begin
      if (be[i]) res[8*i +: 8] = fresh[8*i +: 8];
    end
    return res;
  endfunction

  // Forward only writes that will actually land in storage this edge.
  always_comb begin
    waddrInRange = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (waddr == AW'(i)) waddrInRange = 1'b1;
    end
    wrLive = we && !rst && waddrInRange && !(ZERO_REG != 0 && waddr == '0);
  end

  assign rdata_a = (wrLive && raddr_a == waddr) ? mergeBytes(storedA, wdata, wbe) : storedA;
  assign rdata_b = (wrLive && raddr_b == waddr) ? mergeBytes(storedB, wdata, wbe) : storedB;
`else
  assign rdata_a = storedA;
  assign rdata_b = storedB;
`endif

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: default, ZERO_REG=0 and DEPTH=24 instances share stimulus.
module tb_regfile;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic [4:0]  raddrA;
    logic [4:0]  raddrB;
    logic [31:0] expA;
    logic [31:0] expB;
  } vecT;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] exp;
  } expT;

  logic        clk = 1'b0;
  logic        rst, we;
  logic [4:0]  waddr, raddrA, raddrB;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [31:0] rdA, rdB, nzA, nzB, smA, smB;

  int  testsRun = 0;
  int  testsFailed = 0;
  expT scoreQ[$];
  vecT vecs[9];

  always #5 clk = ~clk;

  regfile dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr_a(raddrA), .rdata_a(rdA), .raddr_b(raddrB), .rdata_b(rdB)
  );

  regfile #(.ZERO_REG(0)) dutNz (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr_a(raddrA), .rdata_a(nzA), .raddr_b(raddrB), .rdata_b(nzB)
  );

  regfile #(.DEPTH(24)) dutSmall (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr_a(raddrA), .rdata_a(smA), .raddr_b(raddrB), .rdata_b(smB)
  );

  function automatic logic [31:0] portValue(input int p);
    case (p)
      0:       return rdA;
      1:       return rdB;
      2:       return nzA;
      3:       return nzB;
      4:       return smA;
      default: return smB;
    endcase
  endfunction

  task automatic expectVal(input string name, input int port, input logic [31:0] v);
    expT e;
    e.name = name;
    e.port = port;
    e.exp  = v;
    scoreQ.push_back(e);
  endtask

  task automatic checkOutput();
    expT e;
    logic [31:0] got;
    while (scoreQ.size() > 0) begin
      e = scoreQ.pop_front();
      got = portValue(e.port);
      testsRun++;
      if (got !== e.exp) begin
        testsFailed++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
  endtask

  task automatic driveWrite(input logic w, input logic [4:0] a, input logic [31:0] d,
                            input logic [3:0] be);
    we = w; waddr = a; wdata = d; wbe = be;
  endtask

  task automatic applyStimulus(input vecT v, input int idx);
    driveWrite(v.we, v.waddr, v.wdata, v.wbe);
    raddrA = v.raddrA;
    raddrB = v.raddrB;
    expectVal($sformatf("vec%0d_a", idx), 0, v.expA);
    expectVal($sformatf("vec%0d_b", idx), 1, v.expB);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Checked one edge after each vector, so expectations hold in both bypass builds.
    vecs[0] = '{1'b1, 5'd3,  32'h12345678, 4'hF, 5'd3,  5'd3,  32'h12345678, 32'h12345678};
    vecs[1] = '{1'b1, 5'd3,  32'hAABBCCDD, 4'h5, 5'd3,  5'd3,  32'h12BB56DD, 32'h12BB56DD};
    vecs[2] = '{1'b1, 5'd3,  32'hFFFFFFFF, 4'h0, 5'd3,  5'd3,  32'h12BB56DD, 32'h12BB56DD};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'hF, 5'd0,  5'd3,  32'h00000000, 32'h12BB56DD};
    vecs[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 4'hF, 5'd31, 5'd0,  32'hCAFEF00D, 32'h00000000};
    vecs[5] = '{1'b0, 5'd3,  32'h00000000, 4'hF, 5'd3,  5'd31, 32'h12BB56DD, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 5'd5,  32'hDEADBEEF, 4'hF, 5'd5,  5'd3,  32'hDEADBEEF, 32'h12BB56DD};
    vecs[7] = '{1'b1, 5'd9,  32'h11111111, 4'hF, 5'd9,  5'd9,  32'h11111111, 32'h11111111};
    vecs[8] = '{1'b1, 5'd31, 32'h55000000, 4'h8, 5'd31, 5'd5,  32'h55FEF00D, 32'hDEADBEEF};

    rst = 1'b1;
    driveWrite(1'b0, 5'd0, 32'h0, 4'h0);
    raddrA = 5'd5;
    raddrB = 5'd31;
    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < 6; p++) expectVal($sformatf("reset_port%0d", p), p, 32'h0);
    checkOutput();

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i], i);
      @(posedge clk);
      #1;
      checkOutput();
    end

    // Read-during-write on r9 with partial byte enables.
    @(negedge clk);
    driveWrite(1'b1, 5'd9, 32'h22222222, 4'h3);
    raddrA = 5'd9;
    raddrB = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    expectVal("bypass_same_a", 0, 32'h11112222);
    expectVal("bypass_same_b", 1, 32'h11112222);
`else
    expectVal("bypass_same_a", 0, 32'h11111111);
    expectVal("bypass_same_b", 1, 32'h11111111);
`endif
    checkOutput();
    @(posedge clk);
    #1;
    expectVal("bypass_edge_a", 0, 32'h11112222);
    checkOutput();
    @(negedge clk);
    we = 1'b0;
    #1;
    expectVal("bypass_next_a", 0, 32'h11112222);
    expectVal("bypass_next_b", 1, 32'h11112222);
    checkOutput();

    // Reset with a simultaneous write to r7: r5 clears, r7 stays zero.
    @(negedge clk);
    rst = 1'b1;
    driveWrite(1'b1, 5'd7, 32'h77777777, 4'hF);
    raddrA = 5'd5;
    raddrB = 5'd7;
    @(posedge clk);
    #1;
    for (int p = 0; p < 6; p++) expectVal($sformatf("rst_write_port%0d", p), p, 32'h0);
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    we = 1'b0;
    #1;
    expectVal("after_rst_r5", 0, 32'h0);
    expectVal("after_rst_r7", 1, 32'h0);
    expectVal("after_rst_r9", 2, 32'h0);
    checkOutput();

    // Register 0: hardwired in the default instance, ordinary with ZERO_REG=0.
    @(negedge clk);
    driveWrite(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF);
    raddrA = 5'd0;
    raddrB = 5'd0;
    #1;
    expectVal("zero_same_main", 0, 32'h0);
    expectVal("zero_same_small", 4, 32'h0);
`ifdef REGFILE_BYPASS_EN
    expectVal("zero_same_nz", 2, 32'hFFFFFFFF);
`else
    expectVal("zero_same_nz", 2, 32'h0);
`endif
    checkOutput();
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    #1;
    expectVal("zero_main_a", 0, 32'h0);
    expectVal("zero_main_b", 1, 32'h0);
    expectVal("zero_nz_a", 2, 32'hFFFFFFFF);
    expectVal("zero_nz_b", 3, 32'hFFFFFFFF);
    expectVal("zero_small_a", 4, 32'h0);
    checkOutput();

    // Out of range on the DEPTH=24 instance: address 30 must not land anywhere.
    @(negedge clk);
    driveWrite(1'b1, 5'd23, 32'h23232323, 4'hF);
    @(negedge clk);
    driveWrite(1'b1, 5'd30, 32'hA5A5A5A5, 4'hF);
    raddrA = 5'd30;
    raddrB = 5'd23;
    #1;
    expectVal("oor_same_small", 4, 32'h0);
    checkOutput();
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    #1;
    expectVal("oor_small_r30", 4, 32'h0);
    expectVal("oor_small_r23", 5, 32'h23232323);
    expectVal("oor_main_r30", 0, 32'hA5A5A5A5);
    checkOutput();
    for (int a = 0; a < 24; a++) begin
      raddrA = 5'(a);
      #1;
      expectVal($sformatf("oor_sweep_r%0d", a), 4, (a == 23) ? 32'h23232323 : 32'h0);
      checkOutput();
    end
    raddrA = 5'd31;
    #1;
    expectVal("oor_small_r31", 4, 32'h0);
    checkOutput();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
